// File: rtl/marie_sequencer.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit MARIE accumulator machine.
// Owns PC/IR/MBR/AC, talks to memory over a req/ack port and to an external combinational ALU.
module marie_sequencer #(
  parameter int          ADDR_W   = 12,
  parameter int          DATA_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out
);

  // state  | meaning
  // FETCH  | request instruction at PC (only once run=1), load IR, PC+1
  // DECODE | single-cycle dispatch on IR opcode
  // MEM    | operand read (LOAD/ADD/SUBT) or AC write (STORE) at IR address
  // ALU    | AC <= alu_result for ADD/SUBT
  // HALT   | absorbing until reset
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_ALU    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUBT   = 4'h4;
  localparam logic [3:0] OP_OUTPUT = 4'h6;
  localparam logic [3:0] OP_HALT   = 4'h7;
  localparam logic [3:0] OP_SKIP   = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'h9;
  localparam logic [3:0] OP_CLEAR  = 4'hA;

  state_t            state;
  logic              req;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mbr;
  logic [DATA_W-1:0] ac;
  logic [3:0]        op;
  logic [ADDR_W-1:0] x;
  logic              skip;

  assign op = ir[DATA_W-1 -: 4];
  assign x  = ir[ADDR_W-1:0];

  always_comb begin
    skip = 1'b0;
    case (ir[11:10])
      2'b00:   skip = ac[DATA_W-1];
      2'b01:   skip = (ac == '0);
      2'b10:   skip = !ac[DATA_W-1] && (ac != '0);
      default: skip = 1'b0;
    endcase
  end

  // req is registered and pre-decided on entry to FETCH/MEM so the memory port is Moore
  // and a zero-wait memory can ack in the first cycle of each state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      req       <= 1'b0;
      pc        <= ADDR_W'(RESET_PC);
      ir        <= '0;
      mbr       <= '0;
      ac        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!req) begin
            req <= run;
          end else if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            req   <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUBT: begin
              req   <= 1'b1;
              state <= S_MEM;
            end
            OP_OUTPUT: begin
              out_data  <= ac;
              out_valid <= 1'b1;
              req       <= run;
              state     <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            OP_SKIP: begin
              if (skip) pc <= pc + ADDR_W'(1);
              req   <= run;
              state <= S_FETCH;
            end
            OP_JUMP: begin
              pc    <= x;
              req   <= run;
              state <= S_FETCH;
            end
            OP_CLEAR: begin
              ac    <= '0;
              req   <= run;
              state <= S_FETCH;
            end
            default: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            case (op)
              OP_LOAD: begin
                ac    <= mem_rdata;
                req   <= run;
                state <= S_FETCH;
              end
              OP_STORE: begin
                req   <= run;
                state <= S_FETCH;
              end
              default: begin
                mbr   <= mem_rdata;
                req   <= 1'b0;
                state <= S_ALU;
              end
            endcase
          end
        end
        S_ALU: begin
          ac    <= alu_result;
          req   <= run;
          state <= S_FETCH;
        end
        S_HALT: begin
          req <= 1'b0;
        end
        default: begin
          req   <= 1'b0;
          state <= S_HALT;
        end
      endcase
    end
  end

  assign mem_req      = req;
  assign mem_addr     = (state == S_MEM) ? x : pc;
  assign mem_we       = req && (state == S_MEM) && (op == OP_STORE);
  assign mem_wdata    = ac;
  assign alu_opcode   = ((state == S_ALU) && (op == OP_SUBT)) ? 4'b0001 : 4'b0000;
  assign alu_operand1 = ac;
  assign alu_operand2 = mbr;
  assign pc_out       = pc;
  assign acc_out      = ac;

endmodule
